control_sequencer: RTL

//  Hardwired control unit for the 32-bit bus datapath. Fetches, decodes IR[31:27] and drives the datapath enables
//  (PCout, MARin, ZLowIn, Gra/Grb/Grc, ...) one T-step per clock.

---
 rtl/cpu_ctrl_pkg.sv | 91 +++++++++
 rtl/control_sequencer_decoder.sv | 28 ++
 rtl/control_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// T-step state encoding, opcode class record and the control-word bundle.
package cpu_ctrl_pkg;

    localparam int IR_W  = 32;
    localparam int OPC_W = 5;

    // Load/store and immediate-load
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    // Register-register ALU range: add .. shra
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01011;
    // Register-immediate ALU range: addi .. ori
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    // Two-register multiply/divide writing HI/LO
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
    // Single-operand ALU ops
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    // Special-register moves and control
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // ALU operation used for effective-address calculation
    localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;

    // One state per T-step plus the terminal HALT state
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    // One-hot instruction class; exactly one field is set for any opcode
    typedef struct packed {
        logic rrr;
        logic imm;
        logic unary;
        logic muldiv;
        logic ld;
        logic ldi;
        logic st;
        logic mfhi;
        logic mflo;
        logic nop;
        logic halt;
    } op_class_t;

    // Full control word driven toward the datapath in one T-step
    typedef struct packed {
        logic             run;
        logic [OPC_W-1:0] alu_op;
        logic             pc_out;
        logic             zlow_out;
        logic             zhigh_out;
        logic             mdr_out;
        logic             hi_out;
        logic             lo_out;
        logic             ba_out;
        logic             c_out;
        logic             r_out;
        logic             pc_in;
        logic             mar_in;
        logic             mdr_in;
        logic             ir_in;
        logic             y_in;
        logic             zlow_in;
        logic             hi_in;
        logic             lo_in;
        logic             r_in;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             inc_pc;
        logic             read;
        logic             write;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_decoder.sv
// opcode_class_decoder: maps the 5-bit opcode onto a one-hot instruction
// class. Every opcode without a defined meaning falls into the HALT class.
module opcode_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output op_class_t        class_o
);

    // Pure table lookup; default class covers halt and all unused codes
    always_comb begin
        class_o = '0;
        case (opcode_i) inside
            OP_LD:             class_o.ld     = 1'b1;
            OP_LDI:            class_o.ldi    = 1'b1;
            OP_ST:             class_o.st     = 1'b1;
            [OP_ADD:OP_SHRA]:  class_o.rrr    = 1'b1;
            [OP_ADDI:OP_ORI]:  class_o.imm    = 1'b1;
            OP_DIV, OP_MUL:    class_o.muldiv = 1'b1;
            OP_NEG, OP_NOT:    class_o.unary  = 1'b1;
            OP_MFHI:           class_o.mfhi   = 1'b1;
            OP_MFLO:           class_o.mflo   = 1'b1;
            OP_NOP:            class_o.nop    = 1'b1;
            default:           class_o.halt   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the 32-bit bus datapath.
// Steps fetch (T0-T2) and a per-class execute sequence, one T-step per clock.
// Optional build macro MEM_WAIT_EN: memory steps (T1, ld T6, st T7) hold
// until MemReady is seen high; without it every step is a single cycle.
// Handshake: MemReady is a level "memory done" qualifier; a memory step
// advances on the first rising Clock edge where MemReady=1, and Reset always
// wins over a pending hold.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [IR_W-1:0]  IR,
    input  logic             MemReady,
    output logic             PCout,
    output logic             ZLowout,
    output logic             ZHighout,
    output logic             MDRout,
    output logic             HIout,
    output logic             LOout,
    output logic             BAout,
    output logic             Cout,
    output logic             Rout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             HIin,
    output logic             LOin,
    output logic             Rin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic [OPC_W-1:0] ALU_op,
    output logic             Run,
    output state_e           dbg_state_o
);

    state_e           state_q;
    state_e           state_d;
    logic [OPC_W-1:0] opcode;
    op_class_t        cls;
    logic             mem_wait;
    ctrl_t            ctrl;

    assign opcode = IR[IR_W-1 -: OPC_W];

    // Operand fields are consumed by the datapath, not by the sequencer
    logic unused_ir;
    assign unused_ir = ^IR[IR_W-OPC_W-1:0];

`ifdef MEM_WAIT_EN
    assign mem_wait = ~MemReady;
`else
    assign mem_wait = 1'b0;
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
`endif

    opcode_class_decoder u_decoder (
        .opcode_i (opcode),
        .class_o  (cls)
    );

    // State register; Reset restarts fetch from T0 and aborts any instruction
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next T-step selection by current step and instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = mem_wait ? S_T1 : S_T2;
            S_T2: state_d = cls.nop ? S_T0 : S_T3;
            S_T3: begin
                if (cls.halt) begin
                    state_d = S_HALT;
                end else if (cls.mfhi || cls.mflo) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: state_d = cls.unary ? S_T0 : S_T5;
            S_T5: state_d = (cls.muldiv || cls.ld || cls.st) ? S_T6 : S_T0;
            S_T6: begin
                if (cls.muldiv) begin
                    state_d = S_T0;
                end else if (cls.ld && mem_wait) begin
                    state_d = S_T6;
                end else begin
                    state_d = S_T7;
                end
            end
            S_T7: state_d = (cls.st && mem_wait) ? S_T7 : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Control word decode; everything is forced low while Reset is high
    always_comb begin
        ctrl = '0;
        if (!Reset) begin
            ctrl.run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    ctrl.pc_out  = 1'b1;
                    ctrl.mar_in  = 1'b1;
                    ctrl.inc_pc  = 1'b1;
                    ctrl.zlow_in = 1'b1;
                end
                S_T1: begin
                    ctrl.zlow_out = 1'b1;
                    ctrl.pc_in    = 1'b1;
                    ctrl.read     = 1'b1;
                    ctrl.mdr_in   = 1'b1;
                end
                S_T2: begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                end
                S_T3: begin
                    if (cls.rrr || cls.imm) begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end else if (cls.unary) begin
                        ctrl.grb     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        ctrl.alu_op  = opcode;
                    end else if (cls.muldiv) begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end else if (cls.ld || cls.ldi || cls.st) begin
                        // BAout makes an R0 base read as zero on the bus
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end else if (cls.mfhi) begin
                        ctrl.hi_out = 1'b1;
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end else if (cls.mflo) begin
                        ctrl.lo_out = 1'b1;
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                end
                S_T4: begin
                    if (cls.rrr) begin
                        ctrl.grc     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        ctrl.alu_op  = opcode;
                    end else if (cls.imm) begin
                        ctrl.c_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        ctrl.alu_op  = opcode;
                    end else if (cls.unary) begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end else if (cls.muldiv) begin
                        ctrl.grb     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                    end else if (cls.ld || cls.ldi || cls.st) begin
                        ctrl.c_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        ctrl.alu_op  = ALU_ADD;
                    end
                end
                S_T5: begin
                    if (cls.rrr || cls.imm || cls.ldi) begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end else if (cls.muldiv) begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.lo_in    = 1'b1;
                    end else if (cls.ld || cls.st) begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                    end
                end
                S_T6: begin
                    if (cls.muldiv) begin
                        ctrl.zhigh_out = 1'b1;
                        ctrl.hi_in     = 1'b1;
                    end else if (cls.ld) begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end else if (cls.st) begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                end
                S_T7: begin
                    if (cls.ld) begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end else if (cls.st) begin
                        ctrl.write = 1'b1;
                    end
                end
                default: ctrl.run = 1'b0;
            endcase
        end
    end

    assign Run         = ctrl.run;
    assign ALU_op      = ctrl.alu_op;
    assign PCout       = ctrl.pc_out;
    assign ZLowout     = ctrl.zlow_out;
    assign ZHighout    = ctrl.zhigh_out;
    assign MDRout      = ctrl.mdr_out;
    assign HIout       = ctrl.hi_out;
    assign LOout       = ctrl.lo_out;
    assign BAout       = ctrl.ba_out;
    assign Cout        = ctrl.c_out;
    assign Rout        = ctrl.r_out;
    assign PCin        = ctrl.pc_in;
    assign MARin       = ctrl.mar_in;
    assign MDRin       = ctrl.mdr_in;
    assign IRin        = ctrl.ir_in;
    assign Yin         = ctrl.y_in;
    assign ZLowIn      = ctrl.zlow_in;
    assign HIin        = ctrl.hi_in;
    assign LOin        = ctrl.lo_in;
    assign Rin         = ctrl.r_in;
    assign Gra         = ctrl.gra;
    assign Grb         = ctrl.grb;
    assign Grc         = ctrl.grc;
    assign IncPC       = ctrl.inc_pc;
    assign Read        = ctrl.read;
    assign Write       = ctrl.write;
    assign dbg_state_o = state_q;

endmodule
